// File: rtl/cplx_product_accumulator.sv
// Complex dot-product accumulator: sums bursts of complex products, presents each sum on a
// single-entry valid/ready buffer. Define CPLX_ACC_SAT_EN for saturating adds with overflow flag.

module cplx_acc_lane #(
    parameter int ACC_W = 20
) (
    input  logic [ACC_W-1:0] base,
    input  logic [15:0]      din,
`ifdef CPLX_ACC_SAT_EN
    output logic             ovf,
`endif
    output logic [ACC_W-1:0] sum
);
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] raw;

    assign ext = {{(ACC_W-16){din[15]}}, din};
    assign raw = base + ext;

`ifdef CPLX_ACC_SAT_EN
    localparam logic [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

    // Signed overflow: operands agree in sign but the result does not.
    assign ovf = (base[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != base[ACC_W-1]);
    assign sum = ovf ? (base[ACC_W-1] ? MINV : MAXV) : raw;
`else
    assign sum = raw;
`endif
endmodule

module cplx_product_accumulator #(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [15:0]                  in_re,
    input  logic [15:0]                  in_im,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_re,
    output logic [ACC_W-1:0]             out_im,
    output logic [$clog2(N_TERMS+1)-1:0] out_count,
    output logic                         out_ovf
);
    localparam int CW = $clog2(N_TERMS+1);
    localparam int NL = 2;  // lane 0 = real, lane 1 = imaginary

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]                 state;
    logic [CW-1:0]              count;
    logic [CW-1:0]              cnt_nxt;
    logic [NL-1:0][ACC_W-1:0]   acc;
    logic [NL-1:0][ACC_W-1:0]   base;
    logic [NL-1:0][ACC_W-1:0]   sum;
    logic [NL-1:0][15:0]        din;
    logic                       accept;
    logic                       close;

    assign in_ready = (state != HOLD);
    assign accept   = in_valid & in_ready;
    assign din      = {in_im, in_re};
    // A burst starting in IDLE adds onto zero, so the first beat loads sext(in).
    assign base     = (state == ACC) ? acc : '0;
    assign cnt_nxt  = (state == ACC) ? count + CW'(1) : CW'(1);
    assign close    = accept & (in_last | (cnt_nxt == CW'(N_TERMS)));

`ifdef CPLX_ACC_SAT_EN
    logic [NL-1:0] lane_ovf;
    logic          ovf_r;
    logic          ovf_nxt;
    logic          ovf_q;

    assign ovf_nxt = ((state == ACC) & ovf_r) | (|lane_ovf);
    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

    genvar l;
    generate
        for (l = 0; l < NL; l++) begin : g_lane
            cplx_acc_lane #(.ACC_W(ACC_W)) u_lane (
                .base (base[l]),
                .din  (din[l]),
`ifdef CPLX_ACC_SAT_EN
                .ovf  (lane_ovf[l]),
`endif
                .sum  (sum[l])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_count <= '0;
`ifdef CPLX_ACC_SAT_EN
            ovf_r     <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (close) begin
                        out_re    <= sum[0];
                        out_im    <= sum[1];
                        out_count <= cnt_nxt;
                        out_valid <= 1'b1;
                        acc       <= '0;
                        count     <= '0;
                        state     <= HOLD;
`ifdef CPLX_ACC_SAT_EN
                        ovf_q     <= ovf_nxt;
                        ovf_r     <= 1'b0;
`endif
                    end else if (accept) begin
                        acc   <= sum;
                        count <= cnt_nxt;
                        state <= ACC;
`ifdef CPLX_ACC_SAT_EN
                        ovf_r <= ovf_nxt;
`endif
                    end
                end
                HOLD: begin
                    // Result fields stay put after the handshake; only the valid drops.
                    if (out_valid & out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cplx_product_accumulator.sv
// Bench for cplx_product_accumulator: directed steps plus random bursts against an integer model.
module tb_cplx_product_accumulator;
    localparam int N_TERMS = 4;
    localparam int ACC_W   = 17;
    localparam longint MAXV = 65535;
    localparam longint MINV = -65536;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [ACC_W-1:0] out_re;
    logic [ACC_W-1:0] out_im;
    logic [$clog2(N_TERMS+1)-1:0] out_count;
    logic        out_ovf;

    int errors = 0;
    int checks = 0;

    cplx_product_accumulator #(.N_TERMS(N_TERMS), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_count(out_count), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input int re, input int im, input bit last);
        chk("in_ready_before_beat", {31'd0, in_ready}, 1);
        in_valid = 1'b1;
        in_re    = 16'(re);
        in_im    = 16'(im);
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_res(input string tag, input int re, input int im, input int cnt, input int ovf);
        chk({tag, "_valid"}, {31'd0, out_valid}, 1);
        chk({tag, "_re"}, $signed(out_re), re);
        chk({tag, "_im"}, $signed(out_im), im);
        chk({tag, "_count"}, {29'd0, out_count}, cnt);
        chk({tag, "_ovf"}, {31'd0, out_ovf}, ovf);
    endtask

    // Handshake with out_ready=1: one HOLD cycle, then the buffer empties.
    task automatic drain(input string tag);
        out_ready = 1'b1;
        chk({tag, "_hold_ready"}, {31'd0, in_ready}, 0);
        step();
        chk({tag, "_drained_valid"}, {31'd0, out_valid}, 0);
        chk({tag, "_drained_ready"}, {31'd0, in_ready}, 1);
    endtask

    // Reference: running sum in wide integers, clamped per add or wrapped at the end.
    function automatic void model(input int v[$], output int r, output int o);
        longint s = 0;
        o = 0;
        foreach (v[i]) begin
            s += v[i];
`ifdef CPLX_ACC_SAT_EN
            if (s > MAXV) begin s = MAXV; o = 1; end
            else if (s < MINV) begin s = MINV; o = 1; end
`endif
        end
`ifndef CPLX_ACC_SAT_EN
        s = ((s % 131072) + 131072) % 131072;
        if (s >= 65536) s -= 131072;
`endif
        r = int'(s);
    endfunction

    initial begin
        int qre[$];
        int qim[$];
        int er, ei, oe, oi, n, re, im;
        bit last, rdy;

        rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; in_last = 1'b0; out_ready = 1'b1;

        // Reset state
        step(); step();
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_re", $signed(out_re), 0);
        chk("rst_out_im", $signed(out_im), 0);
        chk("rst_out_count", {29'd0, out_count}, 0);
        chk("rst_out_ovf", {31'd0, out_ovf}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);

        // Full burst closes on the N_TERMS-th beat
        beat(100, -50, 0);
        chk("t2_no_early_valid", {31'd0, out_valid}, 0);
        beat(200, 25, 0);
        beat(-300, 10, 0);
        beat(1, 1, 0);
        expect_res("t2", 1, -14, 4, 0);
        drain("t2");

        // Early close, then single-beat burst from IDLE
        beat(7, 8, 0);
        beat(9, -10, 1);
        expect_res("t3a", 16, -2, 2, 0);
        drain("t3a");
        beat(5, 5, 1);
        expect_res("t3b", 5, 5, 1, 0);

        // Backpressure: held result, input ignored
        out_ready = 1'b0;
        in_valid = 1'b1; in_re = 16'd999; in_im = 16'd999;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_ready", {31'd0, in_ready}, 0);
            chk("t4_hold_valid", {31'd0, out_valid}, 1);
            chk("t4_hold_re", $signed(out_re), 5);
            chk("t4_hold_count", {29'd0, out_count}, 1);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t4_hs_valid", {31'd0, out_valid}, 0);
        chk("t4_keep_re", $signed(out_re), 5);
        beat(2, 3, 0);
        beat(4, -1, 1);
        expect_res("t4", 6, 2, 2, 0);
        drain("t4");

        // Overflow at ACC_W=17
        for (int i = 0; i < 4; i++) beat(32767, -32768, 0);
`ifdef CPLX_ACC_SAT_EN
        expect_res("t5", 65535, -65536, 4, 1);
`else
        expect_res("t5", -4, 0, 4, 0);
`endif
        drain("t5");

        // Reset mid-burst discards partial sum
        beat(10, 10, 0);
        beat(10, 10, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_valid", {31'd0, out_valid}, 0);
        chk("t6_rst_ready", {31'd0, in_ready}, 1);
        beat(3, 4, 0);
        chk("t6_mid_valid", {31'd0, out_valid}, 0);
        beat(1, 1, 1);
        expect_res("t6", 4, 5, 2, 0);
        drain("t6");

        // Random bursts with idle gaps and random backpressure
        for (int b = 0; b < 40; b++) begin
            qre.delete(); qim.delete();
            n = $urandom_range(N_TERMS, 1);
            rdy = 1'(($urandom_range(1, 0)));
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(3, 0) == 0) begin
                    step();
                    chk("rnd_gap_valid", {31'd0, out_valid}, 0);
                end
                re = int'($urandom_range(65535, 0)) - 32768;
                im = int'($urandom_range(65535, 0)) - 32768;
                qre.push_back(re); qim.push_back(im);
                last = (k == n - 1) && ((n < N_TERMS) || ($urandom_range(1, 0) == 1));
                if (k == n - 1) out_ready = rdy;
                beat(re, im, last);
            end
            model(qre, er, oe);
            model(qim, ei, oi);
            expect_res("rnd", er, ei, n, oe | oi);
            if (!rdy) begin
                for (int h = 0; h < int'($urandom_range(3, 0)); h++) begin
                    step();
                    chk("rnd_bp_valid", {31'd0, out_valid}, 1);
                    chk("rnd_bp_re", $signed(out_re), er);
                end
            end
            drain("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
